// File: rtl/cellrv32_cpu_cp_fpu_f2i_xl_pkg.sv
// Shared constants for the FPU float-to-integer converter: rounding-mode
// codes, operand class indices, exception flag indices and float-format
// geometry helpers.
package cellrv32_cpu_cp_fpu_f2i_xl_pkg;

  // Rounding modes, already resolved by the dispatcher (never DYN)
  localparam logic [2:0] fp_rm_rne_c = 3'b000;
  localparam logic [2:0] fp_rm_rtz_c = 3'b001;
  localparam logic [2:0] fp_rm_rdn_c = 3'b010;
  localparam logic [2:0] fp_rm_rup_c = 3'b011;
  localparam logic [2:0] fp_rm_rmm_c = 3'b100;

  // Operand class one-hot indices
  localparam int fp_class_neg_inf_c     = 0;
  localparam int fp_class_neg_norm_c    = 1;
  localparam int fp_class_neg_denorm_c  = 2;
  localparam int fp_class_neg_zero_c    = 3;
  localparam int fp_class_pos_zero_c    = 4;
  localparam int fp_class_pos_denorm_c  = 5;
  localparam int fp_class_pos_norm_c    = 6;
  localparam int fp_class_pos_inf_c     = 7;
  localparam int fp_class_snan_c        = 8;
  localparam int fp_class_qnan_c        = 9;

  // Exception flag indices
  localparam int fp_exc_nv_c = 0;
  localparam int fp_exc_dz_c = 1;
  localparam int fp_exc_of_c = 2;
  localparam int fp_exc_uf_c = 3;
  localparam int fp_exc_nx_c = 4;

  // Exponent field width for binary32 / binary64
  function automatic int fp_exp_w(input int flen);
    return (flen == 64) ? 11 : 8;
  endfunction

  // Fraction field width for binary32 / binary64
  function automatic int fp_mant_w(input int flen);
    return (flen == 64) ? 52 : 23;
  endfunction

  // Exponent bias for binary32 / binary64
  function automatic int fp_bias(input int flen);
    return (flen == 64) ? 1023 : 127;
  endfunction

endpackage

// File: rtl/cellrv32_cpu_cp_fpu_f2i_xl_if.sv
// Request/response bundle between the FPU op dispatcher and the
// float-to-integer converter.
interface cellrv32_cpu_cp_fpu_f2i_xl_if
  import cellrv32_cpu_cp_fpu_f2i_xl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int FLEN = 32
);
  localparam int EXP_W  = fp_exp_w(FLEN);
  localparam int MANT_W = fp_mant_w(FLEN);

  logic              start_i;
  logic              abort_i;
  logic [2:0]        rmode_i;
  logic              unsigned_i;
  logic              long_i;
  logic              sign_i;
  logic [EXP_W-1:0]  exponent_i;
  logic [MANT_W-1:0] mantissa_i;
  logic [9:0]        class_i;
  logic [XLEN-1:0]   result_o;
  logic [4:0]        flags_o;
  logic              done_o;
  logic              busy_o;

  modport master (
    output start_i, abort_i, rmode_i, unsigned_i, long_i,
           sign_i, exponent_i, mantissa_i, class_i,
    input  result_o, flags_o, done_o, busy_o
  );

  modport slave (
    input  start_i, abort_i, rmode_i, unsigned_i, long_i,
           sign_i, exponent_i, mantissa_i, class_i,
    output result_o, flags_o, done_o, busy_o
  );

endinterface

// File: rtl/cellrv32_cpu_cp_fpu_f2i_xl_rnd.sv
// Integer rounding step: decides whether the truncated magnitude is bumped
// by one from guard/sticky, sign and rounding mode. Purely combinational so
// the fp-to-fp rounder can reuse it.
module cellrv32_cpu_cp_fpu_rnd_int
  import cellrv32_cpu_cp_fpu_f2i_xl_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  input  logic [2:0]       rmode,
  output logic             inc,
  output logic             inexact,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Increment decision per rounding mode, then the WIDTH+1-bit add
  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves one
    // unassigned; otherwise synthesis would infer a latch.
    inc     = 1'b0;
    inexact = guard | sticky;
    case (rmode)
      fp_rm_rne_c: inc = guard & (sticky | mag[0]);
      fp_rm_rdn_c: inc = sign & inexact;
      fp_rm_rup_c: inc = ~sign & inexact;
      fp_rm_rmm_c: inc = guard;
      default:     inc = 1'b0; // RTZ and the reserved codes truncate
    endcase
    {carry, sum} = {1'b0, mag} + {{WIDTH{1'b0}}, inc};
  end

endmodule

// File: rtl/cellrv32_cpu_cp_fpu_f2i_xl.sv
// Multi-cycle float-to-integer converter (FCVT.W/WU, and L/LU when XLEN=64).
// The hidden-1 magnitude is shifted left SHIFT_STEP bits per cycle, rounded
// once, range-checked, and saturated with NV on overflow, NaN or infinity.
module cellrv32_cpu_cp_fpu_f2i_xl
  import cellrv32_cpu_cp_fpu_f2i_xl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  cellrv32_cpu_cp_fpu_f2i_xl_if.slave   bus
);

  localparam int EXP_W  = fp_exp_w(FLEN);
  localparam int MANT_W = fp_mant_w(FLEN);
  localparam int BIAS   = fp_bias(FLEN);
  localparam int N      = XLEN + 1;  // magnitude width incl. one overflow bit
  localparam int EW     = EXP_W + 2; // signed unbiased exponent width
  localparam logic [7:0]      STEP = 8'(SHIFT_STEP);
  localparam logic [XLEN+1:0] ONE  = (XLEN+2)'(1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_SHIFT, S_ROUND, S_FINAL} state_t;

  state_t            state_q;
  logic              op_sign, op_uns, op_long, op_nan, op_inf, op_zero;
  logic [2:0]        op_rm;
  logic [EXP_W-1:0]  op_exp;
  logic [MANT_W-1:0] op_mant;
  logic [N-1:0]      mag_q;
  logic [MANT_W-1:0] frac_q;  // mantissa bits not yet shifted into mag_q
  logic              sticky_q;
  logic [7:0]        cnt_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        flags_q;
  logic              done_q, busy_q;

  logic signed [EW-1:0] e;
  logic [7:0]           w_bits, shamt;
  logic                 early_ovf, prep_final;
  logic [N+MANT_W-1:0]  ext_sh;
  logic                 rnd_inc, rnd_inexact, rnd_carry;
  logic [N-1:0]         rnd_sum;
  logic [XLEN+1:0]      m_full, lim_half, lim_full;
  logic                 rng_ovf;
  logic [XLEN-1:0]      sat_pos, sat_neg, res_raw, res_ext;
  logic [4:0]           flags_nxt;
  logic                 nv, nx;

  assign e          = $signed({2'b00, op_exp}) - $signed(EW'(BIAS));
  assign w_bits     = op_long ? 8'd64 : 8'd32;
  assign early_ovf  = e > $signed({{(EW-8){1'b0}}, w_bits});
  assign prep_final = op_nan | op_inf | op_zero | early_ovf;
  assign shamt      = (cnt_q < STEP) ? cnt_q : STEP;
  assign ext_sh     = {mag_q, frac_q} << shamt;

  cellrv32_cpu_cp_fpu_rnd_int #(.WIDTH(N)) u_rnd (
    .mag     (mag_q),
    .guard   (frac_q[MANT_W-1]),
    .sticky  (sticky_q | (|frac_q[MANT_W-2:0])),
    .sign    (op_sign),
    .rmode   (op_rm),
    .inc     (rnd_inc),
    .inexact (rnd_inexact),
    .sum     (rnd_sum),
    .carry   (rnd_carry)
  );

  // Range limits of the rounded magnitude for the current target width
  assign m_full   = {rnd_carry, rnd_sum};
  assign lim_half = ONE << (w_bits - 8'd1);
  assign lim_full = ONE << w_bits;
  assign rng_ovf  = op_sign ? (op_uns ? (m_full != '0) : (m_full > lim_half))
                            : (op_uns ? (m_full >= lim_full) : (m_full >= lim_half));
  assign sat_pos  = op_uns ? '1 : XLEN'(lim_half - ONE);
  assign sat_neg  = op_uns ? '0 : XLEN'(~lim_half + ONE);

  // Final result and flags, for both the PREP shortcut and the ROUND path
  always_comb begin
    res_raw = '0;
    nv      = 1'b0;
    nx      = 1'b0;
    if (state_q == S_PREP) begin
      if (op_nan) begin
        res_raw = sat_pos;
        nv      = 1'b1;
      end else if (op_inf || early_ovf) begin
        res_raw = op_sign ? sat_neg : sat_pos;
        nv      = 1'b1;
      end
    end else if (rng_ovf) begin
      res_raw = op_sign ? sat_neg : sat_pos;
      nv      = 1'b1;
    end else begin
      res_raw = (op_sign && !op_uns) ? XLEN'(~m_full + ONE) : XLEN'(m_full);
      nx      = rnd_inexact;
    end
    // 32-bit targets are sign-extended from bit 31 for W and WU alike
    res_ext = res_raw;
    if (!op_long) begin
      for (int i = 32; i < XLEN; i++) res_ext[i] = res_raw[31];
    end
    flags_nxt              = '0;
    flags_nxt[fp_exc_nv_c] = nv;
    flags_nxt[fp_exc_nx_c] = nx;
  end

  // Control FSM with operand capture, shifting datapath and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      op_sign  <= 1'b0;
      op_uns   <= 1'b0;
      op_long  <= 1'b0;
      op_nan   <= 1'b0;
      op_inf   <= 1'b0;
      op_zero  <= 1'b0;
      op_rm    <= '0;
      op_exp   <= '0;
      op_mant  <= '0;
      mag_q    <= '0;
      frac_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge values of the others regardless of statement order.
      done_q <= 1'b0;
      if (state_q != S_IDLE && bus.abort_i) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start_i && !bus.abort_i) begin
              op_sign <= bus.sign_i;
              op_uns  <= bus.unsigned_i;
              op_long <= (XLEN == 64) ? bus.long_i : 1'b0;
              op_nan  <= bus.class_i[fp_class_snan_c] | bus.class_i[fp_class_qnan_c];
              op_inf  <= bus.class_i[fp_class_neg_inf_c] | bus.class_i[fp_class_pos_inf_c];
              op_zero <= bus.class_i[fp_class_neg_zero_c] | bus.class_i[fp_class_pos_zero_c];
              op_rm   <= bus.rmode_i;
              op_exp  <= bus.exponent_i;
              op_mant <= bus.mantissa_i;
              busy_q  <= 1'b1;
              state_q <= S_PREP;
            end
          end
          S_PREP: begin
            if (prep_final) begin
              result_q <= res_ext;
              flags_q  <= flags_nxt;
              done_q   <= 1'b1;
              state_q  <= S_FINAL;
            end else if (e < 0) begin
              mag_q <= '0;
              if (e == -1) begin
                frac_q   <= {1'b1, op_mant[MANT_W-1:1]};
                sticky_q <= op_mant[0];
              end else begin
                frac_q   <= '0;
                sticky_q <= 1'b1;
              end
              state_q <= S_ROUND;
            end else begin
              mag_q    <= N'(1);
              frac_q   <= op_mant;
              sticky_q <= 1'b0;
              cnt_q    <= e[7:0];
              state_q  <= (e == 0) ? S_ROUND : S_SHIFT;
            end
          end
          S_SHIFT: begin
            {mag_q, frac_q} <= ext_sh;
            cnt_q           <= cnt_q - shamt;
            if (cnt_q <= STEP) state_q <= S_ROUND;
          end
          S_ROUND: begin
            result_q <= res_ext;
            flags_q  <= flags_nxt;
            done_q   <= 1'b1;
            state_q  <= S_FINAL;
          end
          S_FINAL: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.result_o = result_q;
  assign bus.flags_o  = flags_q;
  assign bus.done_o   = done_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu_f2i_xl.sv
// Directed bench: two converters (SHIFT_STEP 1 and 4, XLEN=64, FLEN=32) see
// the same stimulus; results, flags and completion latency are compared
// against hand-computed values.
module tb_cellrv32_cpu_cp_fpu_f2i_xl;
  import cellrv32_cpu_cp_fpu_f2i_xl_pkg::*;

  localparam logic [4:0] NV = 5'(1) << fp_exc_nv_c;
  localparam logic [4:0] NX = 5'(1) << fp_exc_nx_c;
  localparam logic [4:0] NF = 5'd0;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] r1, r4;
  logic [4:0]  f1, f4;
  int          l1, l4;
  int          n_done;

  always #5 clk = ~clk;

  cellrv32_cpu_cp_fpu_f2i_xl_if #(.XLEN(64), .FLEN(32)) bus1 ();
  cellrv32_cpu_cp_fpu_f2i_xl_if #(.XLEN(64), .FLEN(32)) bus4 ();

  assign bus4.start_i    = bus1.start_i;
  assign bus4.abort_i    = bus1.abort_i;
  assign bus4.rmode_i    = bus1.rmode_i;
  assign bus4.unsigned_i = bus1.unsigned_i;
  assign bus4.long_i     = bus1.long_i;
  assign bus4.sign_i     = bus1.sign_i;
  assign bus4.exponent_i = bus1.exponent_i;
  assign bus4.mantissa_i = bus1.mantissa_i;
  assign bus4.class_i    = bus1.class_i;

  cellrv32_cpu_cp_fpu_f2i_xl #(.XLEN(64), .FLEN(32), .SHIFT_STEP(1)) dut1 (
    .clk_i (clk), .rstn_i (rstn), .bus (bus1)
  );
  cellrv32_cpu_cp_fpu_f2i_xl #(.XLEN(64), .FLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk_i (clk), .rstn_i (rstn), .bus (bus4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] fclass(input logic [31:0] b);
    logic [9:0] c;
    c = '0;
    if (b[30:23] == 8'hFF) begin
      if (b[22:0] == '0) c[b[31] ? fp_class_neg_inf_c : fp_class_pos_inf_c] = 1'b1;
      else               c[b[22] ? fp_class_qnan_c : fp_class_snan_c] = 1'b1;
    end else if (b[30:23] == 8'h00) begin
      if (b[22:0] == '0) c[b[31] ? fp_class_neg_zero_c : fp_class_pos_zero_c] = 1'b1;
      else               c[b[31] ? fp_class_neg_denorm_c : fp_class_pos_denorm_c] = 1'b1;
    end else begin
      c[b[31] ? fp_class_neg_norm_c : fp_class_pos_norm_c] = 1'b1;
    end
    return c;
  endfunction

  // Drive one request; latency counts posedges starting with the one that samples start
  task automatic launch(input logic [31:0] bits, input logic [2:0] rm,
                        input logic uns, input logic lng);
    @(posedge clk);
    @(negedge clk);
    bus1.start_i    = 1'b1;
    bus1.rmode_i    = rm;
    bus1.unsigned_i = uns;
    bus1.long_i     = lng;
    bus1.sign_i     = bits[31];
    bus1.exponent_i = bits[30:23];
    bus1.mantissa_i = bits[22:0];
    bus1.class_i    = fclass(bits);
    @(posedge clk);
    #1;
    // scramble the operand: the converter must work from its captured copy
    bus1.start_i    = 1'b0;
    bus1.rmode_i    = ~rm;
    bus1.unsigned_i = ~uns;
    bus1.long_i     = ~lng;
    bus1.sign_i     = ~bits[31];
    bus1.exponent_i = ~bits[30:23];
    bus1.mantissa_i = ~bits[22:0];
    bus1.class_i    = '0;
  endtask

  task automatic run_op(input logic [31:0] bits, input logic [2:0] rm,
                        input logic uns, input logic lng);
    int n;
    launch(bits, rm, uns, lng);
    l1 = -1; l4 = -1; r1 = 'x; r4 = 'x; f1 = 'x; f4 = 'x;
    n = 1;
    while ((l1 < 0 || l4 < 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (l1 < 0 && bus1.done_o) begin l1 = n; r1 = bus1.result_o; f1 = bus1.flags_o; end
      if (l4 < 0 && bus4.done_o) begin l4 = n; r4 = bus4.result_o; f4 = bus4.flags_o; end
    end
  endtask

  task automatic op(input string tag, input logic [31:0] bits, input logic [2:0] rm,
                    input logic uns, input logic lng,
                    input logic [63:0] exp_r, input logic [4:0] exp_f);
    run_op(bits, rm, uns, lng);
    check({tag, ".res1"}, r1, exp_r);
    check({tag, ".flg1"}, 64'(f1), 64'(exp_f));
    check({tag, ".res4"}, r4, exp_r);
    check({tag, ".flg4"}, 64'(f4), 64'(exp_f));
  endtask

  initial begin
    rstn            = 1'b0;
    bus1.start_i    = 1'b0;
    bus1.abort_i    = 1'b0;
    bus1.rmode_i    = fp_rm_rne_c;
    bus1.unsigned_i = 1'b0;
    bus1.long_i     = 1'b0;
    bus1.sign_i     = 1'b0;
    bus1.exponent_i = '0;
    bus1.mantissa_i = '0;
    bus1.class_i    = '0;
    #1;
    check("rst.result", bus1.result_o, 64'd0);
    check("rst.flags",  64'(bus1.flags_o), 64'd0);
    check("rst.done",   64'(bus1.done_o), 64'd0);
    check("rst.busy",   64'(bus1.busy_o), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // 2.5, W signed, all roundings
    op("p2_5.rne", 32'h40200000, fp_rm_rne_c, 1'b0, 1'b0, 64'd2, NX);
    check("p2_5.lat1", 64'(l1), 64'd4);
    check("p2_5.lat4", 64'(l4), 64'd4);
    op("p2_5.rmm", 32'h40200000, fp_rm_rmm_c, 1'b0, 1'b0, 64'd3, NX);
    op("p2_5.rup", 32'h40200000, fp_rm_rup_c, 1'b0, 1'b0, 64'd3, NX);
    op("p2_5.rtz", 32'h40200000, fp_rm_rtz_c, 1'b0, 1'b0, 64'd2, NX);
    op("p2_5.rsv", 32'h40200000, 3'b110,      1'b0, 1'b0, 64'd2, NX);

    // -1.5, W signed, directed roundings
    op("m1_5.rdn", 32'hBFC00000, fp_rm_rdn_c, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFE, NX);
    check("m1_5.lat1", 64'(l1), 64'd3);
    op("m1_5.rup", 32'hBFC00000, fp_rm_rup_c, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, NX);

    // 0.5 exercises the e=-1 guard path
    op("p0_5.rne", 32'h3F000000, fp_rm_rne_c, 1'b0, 1'b0, 64'd0, NX);
    op("p0_5.rmm", 32'h3F000000, fp_rm_rmm_c, 1'b0, 1'b0, 64'd1, NX);

    // 3e9 for W, WU and L
    op("3e9.w",  32'h4F32D05E, fp_rm_rne_c, 1'b0, 1'b0, 64'h000000007FFFFFFF, NV);
    check("3e9.lat1", 64'(l1), 64'd34);
    check("3e9.lat4", 64'(l4), 64'd11);
    op("3e9.wu", 32'h4F32D05E, fp_rm_rne_c, 1'b1, 1'b0, 64'hFFFFFFFFB2D05E00, NF);
    op("3e9.l",  32'h4F32D05E, fp_rm_rne_c, 1'b0, 1'b1, 64'h00000000B2D05E00, NF);

    // negative unsigned and signed range edges
    op("m0_3.wu", 32'hBE99999A, fp_rm_rtz_c, 1'b1, 1'b0, 64'd0, NX);
    op("m0_7.wu", 32'hBF333333, fp_rm_rne_c, 1'b1, 1'b0, 64'd0, NV);
    op("m1_0.wu", 32'hBF800000, fp_rm_rne_c, 1'b1, 1'b0, 64'd0, NV);
    op("m2p31.w", 32'hCF000000, fp_rm_rne_c, 1'b0, 1'b0, 64'hFFFFFFFF80000000, NF);
    op("m2p63.l", 32'hDF000000, fp_rm_rne_c, 1'b0, 1'b1, 64'h8000000000000000, NF);
    op("p2p63.l", 32'h5F000000, fp_rm_rne_c, 1'b0, 1'b1, 64'h7FFFFFFFFFFFFFFF, NV);
    op("p2p63.lu", 32'h5F000000, fp_rm_rne_c, 1'b1, 1'b1, 64'h8000000000000000, NF);

    // specials
    op("qnan.w",  32'h7FC00000, fp_rm_rne_c, 1'b0, 1'b0, 64'h000000007FFFFFFF, NV);
    check("qnan.lat1", 64'(l1), 64'd2);
    op("minf.l",  32'hFF800000, fp_rm_rne_c, 1'b0, 1'b1, 64'h8000000000000000, NV);
    op("pzero.l", 32'h00000000, fp_rm_rne_c, 1'b0, 1'b1, 64'd0, NF);
    check("pzero.lat1", 64'(l1), 64'd2);
    check("pzero.lat4", 64'(l4), 64'd2);

    // 2^20: SHIFT_STEP=4 finishes in 8 cycles, SHIFT_STEP=1 in 23
    op("p2p20.w", 32'h49800000, fp_rm_rne_c, 1'b0, 1'b0, 64'h0000000000100000, NF);
    check("p2p20.lat4", 64'(l4), 64'd8);
    check("p2p20.lat1", 64'(l1), 64'd23);

    // abort in SHIFT: idle next cycle, no done, outputs held
    launch(32'h4F32D05E, fp_rm_rne_c, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort.busy_before", 64'(bus4.busy_o), 64'd1);
    bus1.abort_i = 1'b1;
    @(posedge clk);
    #1;
    bus1.abort_i = 1'b0;
    check("abort.busy1", 64'(bus1.busy_o), 64'd0);
    check("abort.busy4", 64'(bus4.busy_o), 64'd0);
    check("abort.held_res", bus1.result_o, 64'h0000000000100000);
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus1.done_o || bus4.done_o) n_done++;
    end
    check("abort.no_done", 64'(n_done), 64'd0);
    op("after_abort.l", 32'h4F32D05E, fp_rm_rne_c, 1'b0, 1'b1, 64'h00000000B2D05E00, NF);

    // start together with abort in IDLE does not start
    @(negedge clk);
    bus1.start_i = 1'b1;
    bus1.abort_i = 1'b1;
    @(posedge clk);
    #1;
    bus1.start_i = 1'b0;
    bus1.abort_i = 1'b0;
    check("start_abort.busy", 64'(bus1.busy_o), 64'd0);

    // asynchronous reset mid-operation
    launch(32'hBFC00000, fp_rm_rdn_c, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst.busy",   64'(bus1.busy_o), 64'd0);
    check("mid_rst.result", bus1.result_o, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
